// File: rtl/xhdmigearbox_if.sv
// Word-in / slice-out bundle of the TMDS gearbox: input handshake, slip and error
// controls on the way in; serial-ordered slices and status on the way out.
interface xhdmigearbox_if #(
    parameter int NCH = 3,
    parameter int IW  = 10,
    parameter int OW  = 5
);
    logic              i_stb;
    logic              o_ready;
    logic [NCH*IW-1:0] i_word;
    logic              i_slip;
    logic              i_clr_err;
    logic [NCH*OW-1:0] o_data;
    logic              o_valid;
    logic              o_underflow;

    modport master (
        output i_stb, i_word, i_slip, i_clr_err,
        input  o_ready, o_data, o_valid, o_underflow
    );

    modport slave (
        input  i_stb, i_word, i_slip, i_clr_err,
        output o_ready, o_data, o_valid, o_underflow
    );
endinterface

// File: rtl/xhdmigearbox.sv
// TMDS word gearbox: NCH parallel IW-bit words in, OW serial-ordered bits per channel
// out every clock, with selectable bit order, one-bit alignment slip and sticky underflow.
module xhdmigearbox #(
    parameter int NCH       = 3,
    parameter int IW        = 10,
    parameter int OW        = 5,
    parameter int LSB_FIRST = 0
) (
    input  logic          i_clk,
    input  logic          i_reset,
    xhdmigearbox_if.slave bus
);
    localparam int BW = 2 * IW;
    localparam int FW = $clog2(BW + 1);
    localparam logic [FW-1:0] IW_F   = FW'(IW);
    localparam logic [FW-1:0] OW_F   = FW'(OW);
    localparam logic [FW-1:0] OW1_F  = FW'(OW + 1);
    localparam logic [FW-1:0] ROOM_F = FW'(BW - IW);

    logic [FW-1:0]     fill_reg;
    logic [FW-1:0]     fill_next;
    logic [FW-1:0]     drop;
    logic              accept;
    logic              drain;
    logic              slip_ok;
    logic              started_reg;
    logic              underflow_reg;
    logic              valid_reg;
    logic [NCH*OW-1:0] data_reg;
    logic [NCH*OW-1:0] slices;

    assign bus.o_ready = (fill_reg <= ROOM_F);
    assign accept      = bus.i_stb && bus.o_ready;
    assign drain       = (fill_reg >= OW_F);
    assign slip_ok     = bus.i_slip && (fill_reg >= OW1_F);

    always_comb begin
        drop = '0;
        if (drain) begin
            drop = slip_ok ? OW1_F : OW_F;
        end
    end

    assign fill_next = fill_reg - drop + (accept ? IW_F : '0);

    // Oldest bit lives at buf_reg[BW-1]; bits past the fill level are kept at zero so an
    // incoming word can simply be OR-ed in behind the surviving contents.
    genvar gi, bi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_ch
            logic [IW-1:0] word;
            logic [BW-1:0] buf_reg;
            logic [BW-1:0] kept;
            logic [BW-1:0] appended;

            if (LSB_FIRST != 0) begin : g_rev
                for (bi = 0; bi < IW; bi++) begin : g_bit
                    assign word[bi] = bus.i_word[gi*IW + IW - 1 - bi];
                end
            end else begin : g_fwd
                assign word = bus.i_word[gi*IW +: IW];
            end

            assign slices[gi*OW +: OW] = slip_ok ? buf_reg[BW-2 -: OW] : buf_reg[BW-1 -: OW];
            assign kept     = buf_reg << drop;
            assign appended = kept | ({word, {IW{1'b0}}} >> (fill_reg - drop));

            always_ff @(posedge i_clk or posedge i_reset) begin
                if (i_reset) begin
                    buf_reg <= '0;
                end else begin
                    buf_reg <= accept ? appended : kept;
                end
            end
        end
    endgenerate

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            fill_reg      <= '0;
            started_reg   <= 1'b0;
            underflow_reg <= 1'b0;
            valid_reg     <= 1'b0;
            data_reg      <= '0;
        end else begin
            fill_reg  <= fill_next;
            valid_reg <= drain;
            data_reg  <= drain ? slices : '0;
            if (drain) begin
                started_reg <= 1'b1;
            end
            // A fresh starvation outranks a clear arriving on the same edge
            if (!drain && started_reg) begin
                underflow_reg <= 1'b1;
            end else if (bus.i_clr_err) begin
                underflow_reg <= 1'b0;
            end
        end
    end

    assign bus.o_data      = data_reg;
    assign bus.o_valid     = valid_reg;
    assign bus.o_underflow = underflow_reg;
endmodule
